// File: rtl/in_service_8259a.sv
// ---------------------------------------------------------------------------
// in_service_8259a
//   In-Service Register (ISR) of an 8259A-compatible interrupt controller.
//   Latches the level granted by the priority resolver, clears levels on
//   end-of-interrupt, and reports the highest-priority level still in service.
//
// Ports
//   clock                    in   1  system clock, rising-edge active
//   reset                    in   1  synchronous, active-high reset
//   priority_rotate          in   3  lowest-priority level (7 -> IR0 highest)
//   interrupt_special_mask   in   8  special-mask bits, ignored for highest level
//   interrupt                in   8  granted request from the priority resolver
//   latch_in_service         in   1  strobe: OR interrupt into the ISR
//   end_of_interrupt         in   8  mask of ISR levels to clear
//   in_service_register      out  8  current ISR contents
//   highest_level_in_service out  8  one-hot highest in-service level, or 0
// ---------------------------------------------------------------------------
module in_service_8259a (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] priority_rotate,
  input  logic [7:0] interrupt_special_mask,
  input  logic [7:0] interrupt,
  input  logic       latch_in_service,
  input  logic [7:0] end_of_interrupt,
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service
);

  function automatic logic [7:0] rotate_right(input logic [7:0] value,
                                              input logic [2:0] amount);
    logic [15:0] doubled;
    doubled      = {value, value} >> amount;
    rotate_right = doubled[7:0];
  endfunction

  function automatic logic [7:0] rotate_left(input logic [7:0] value,
                                             input logic [2:0] amount);
    logic [15:0] doubled;
    doubled     = {value, value} << amount;
    rotate_left = doubled[15:8];
  endfunction

  logic [2:0] rotate_amount;
  logic [7:0] masked_isr;
  logic [7:0] rotated_isr;
  logic [7:0] lowest_rotated;
  logic [7:0] next_highest;
  logic [7:0] next_isr;

  // Rotating the highest-priority level down to bit 0 turns the priority
  // search into a plain "lowest set bit" isolation; rotate back afterwards.
  always_comb begin
    rotate_amount  = priority_rotate + 3'd1;
    masked_isr     = in_service_register & ~interrupt_special_mask;
    rotated_isr    = rotate_right(masked_isr, rotate_amount);
    lowest_rotated = rotated_isr & (~rotated_isr + 8'd1);
    next_highest   = rotate_left(lowest_rotated, rotate_amount);
  end

  // Clear before set, so a level latched and cleared together stays set.
  always_comb begin
    next_isr = in_service_register & ~end_of_interrupt;
    if (latch_in_service)
      next_isr = next_isr | interrupt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_service_register      <= '0;
      highest_level_in_service <= '0;
    end else begin
      in_service_register      <= next_isr;
      highest_level_in_service <= next_highest;
    end
  end

endmodule

// File: tb/tb_in_service_8259a.sv
module tb_in_service_8259a;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] priority_rotate;
  logic [7:0] interrupt_special_mask;
  logic [7:0] interrupt;
  logic       latch_in_service;
  logic [7:0] end_of_interrupt;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;

  in_service_8259a dut (
    .clock                    (clock),
    .reset                    (reset),
    .priority_rotate          (priority_rotate),
    .interrupt_special_mask   (interrupt_special_mask),
    .interrupt                (interrupt),
    .latch_in_service         (latch_in_service),
    .end_of_interrupt         (end_of_interrupt),
    .in_service_register      (in_service_register),
    .highest_level_in_service (highest_level_in_service)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       rst;
    logic [2:0] rot;
    logic [7:0] mask;
    logic [7:0] intr;
    logic       latch;
    logic [7:0] eoi;
    logic [7:0] exp_isr;
    logic [7:0] exp_high;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] isr;
    logic [7:0] high;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] m_isr;

  task automatic add(input string name, input logic rst, input logic [2:0] rot,
                     input logic [7:0] mask, input logic [7:0] intr,
                     input logic latch, input logic [7:0] eoi,
                     input logic [7:0] exp_isr, input logic [7:0] exp_high);
    vec_t v;
    v.name = name; v.rst = rst; v.rot = rot; v.mask = mask; v.intr = intr;
    v.latch = latch; v.eoi = eoi; v.exp_isr = exp_isr; v.exp_high = exp_high;
    vecs.push_back(v);
  endtask

  // Priority scan by walking levels in priority order (independent of the
  // rotate/isolate formulation).
  function automatic logic [7:0] ref_high(input logic [7:0] isr,
                                          input logic [7:0] mask,
                                          input logic [2:0] rot);
    logic [7:0] m;
    logic       found;
    int unsigned lvl;
    m = isr & ~mask;
    found = 1'b0;
    ref_high = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      lvl = (32'(rot) + 1 + i) % 8;
      if (!found && m[lvl]) begin
        ref_high = 8'd1 << lvl;
        found = 1'b1;
      end
    end
  endfunction

  task automatic compare(input string name, input logic [7:0] got,
                         input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, check after the edge.
  task automatic cycle(input string name, input logic rst, input logic [2:0] rot,
                       input logic [7:0] mask, input logic [7:0] intr,
                       input logic latch, input logic [7:0] eoi,
                       input logic [7:0] exp_isr, input logic [7:0] exp_high);
    exp_t e;
    @(negedge clock);
    reset = rst; priority_rotate = rot; interrupt_special_mask = mask;
    interrupt = intr; latch_in_service = latch; end_of_interrupt = eoi;
    e.name = name; e.isr = exp_isr; e.high = exp_high;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, got isr %h", name, in_service_register);
    end else begin
      e = sb.pop_front();
      compare({e.name, ".isr"}, in_service_register, e.isr);
      compare({e.name, ".high"}, highest_level_in_service, e.high);
    end
  endtask

  // Model-driven cycle: expectation comes from the reference model.
  task automatic model_cycle(input string name, input logic rst, input logic [2:0] rot,
                             input logic [7:0] mask, input logic [7:0] intr,
                             input logic latch, input logic [7:0] eoi);
    logic [7:0] eh;
    logic [7:0] ei;
    eh = rst ? 8'h00 : ref_high(m_isr, mask, rot);
    ei = rst ? 8'h00 : ((m_isr & ~eoi) | (latch ? intr : 8'h00));
    m_isr = ei;
    cycle(name, rst, rot, mask, intr, latch, eoi, ei, eh);
  endtask

  initial begin
    reset = 1'b1; priority_rotate = 3'd7; interrupt_special_mask = '0;
    interrupt = '0; latch_in_service = 1'b0; end_of_interrupt = '0;

    //   name         rst rot  mask   intr  lat eoi    isr    high
    add("reset0",     1, 7, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00);
    add("reset1",     1, 7, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00);
    add("idle0",      0, 7, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00);
    add("idle1",      0, 7, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00);
    add("latch80",    0, 7, 8'h00, 8'h80, 1, 8'h00, 8'h80, 8'h00);
    add("latch40",    0, 7, 8'h00, 8'h40, 1, 8'h00, 8'hC0, 8'h80);
    add("latch20",    0, 7, 8'h00, 8'h20, 1, 8'h00, 8'hE0, 8'h40);
    add("latch10",    0, 7, 8'h00, 8'h10, 1, 8'h00, 8'hF0, 8'h20);
    add("latch08",    0, 7, 8'h00, 8'h08, 1, 8'h00, 8'hF8, 8'h10);
    add("latch04",    0, 7, 8'h00, 8'h04, 1, 8'h00, 8'hFC, 8'h08);
    add("latch02",    0, 7, 8'h00, 8'h02, 1, 8'h00, 8'hFE, 8'h04);
    add("latch01",    0, 7, 8'h00, 8'h01, 1, 8'h00, 8'hFF, 8'h02);
    add("full",       0, 7, 8'h00, 8'h00, 0, 8'h00, 8'hFF, 8'h01);
    add("eoi01",      0, 7, 8'h00, 8'h00, 0, 8'h01, 8'hFE, 8'h01);
    add("eoi02",      0, 7, 8'h00, 8'h00, 0, 8'h02, 8'hFC, 8'h02);
    add("eoi04",      0, 7, 8'h00, 8'h00, 0, 8'h04, 8'hF8, 8'h04);
    add("eoi08",      0, 7, 8'h00, 8'h00, 0, 8'h08, 8'hF0, 8'h08);
    add("eoi10",      0, 7, 8'h00, 8'h00, 0, 8'h10, 8'hE0, 8'h10);
    add("eoi20",      0, 7, 8'h00, 8'h00, 0, 8'h20, 8'hC0, 8'h20);
    add("eoi40",      0, 7, 8'h00, 8'h00, 0, 8'h40, 8'h80, 8'h40);
    add("eoi80",      0, 7, 8'h00, 8'h00, 0, 8'h80, 8'h00, 8'h80);
    add("empty",      0, 7, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00);
    add("rot_fill",   0, 3, 8'h00, 8'hFF, 1, 8'h00, 8'hFF, 8'h00);
    add("rot_high",   0, 3, 8'h00, 8'h00, 0, 8'h00, 8'hFF, 8'h10);
    add("rot_eoi10",  0, 3, 8'h00, 8'h00, 0, 8'h10, 8'hEF, 8'h10);
    add("rot_next",   0, 3, 8'h00, 8'h00, 0, 8'h00, 8'hEF, 8'h20);
    add("rot_eoi20",  0, 3, 8'h00, 8'h00, 0, 8'h20, 8'hCF, 8'h20);
    add("rot_eoi40",  0, 3, 8'h00, 8'h00, 0, 8'h40, 8'h8F, 8'h40);
    add("rot_eoi80",  0, 3, 8'h00, 8'h00, 0, 8'h80, 8'h0F, 8'h80);
    add("rot_wrap",   0, 3, 8'h00, 8'h00, 0, 8'h00, 8'h0F, 8'h01);
    add("rot_clear",  0, 7, 8'h00, 8'h00, 0, 8'h0F, 8'h00, 8'h01);
    add("sm_fill",    0, 7, 8'h00, 8'h0C, 1, 8'h00, 8'h0C, 8'h00);
    add("sm_mask04",  0, 7, 8'h04, 8'h00, 0, 8'h00, 8'h0C, 8'h08);
    add("sm_mask0c",  0, 7, 8'h0C, 8'h00, 0, 8'h00, 8'h0C, 8'h00);
    add("sm_unmask",  0, 7, 8'h00, 8'h00, 0, 8'h00, 8'h0C, 8'h04);
    add("sim_prep",   0, 7, 8'h00, 8'h01, 1, 8'h0C, 8'h01, 8'h04);
    add("sim_same",   0, 7, 8'h00, 8'h01, 1, 8'h01, 8'h01, 8'h01);
    add("sim_other",  0, 7, 8'h00, 8'h02, 1, 8'h01, 8'h02, 8'h01);
    add("sim_settle", 0, 7, 8'h00, 8'h00, 0, 8'h00, 8'h02, 8'h02);
    add("rst_mid",    1, 7, 8'h00, 8'h80, 1, 8'h00, 8'h00, 8'h00);
    add("rst_after",  0, 7, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00);
    add("multi",      0, 7, 8'h00, 8'h81, 1, 8'h00, 8'h81, 8'h00);
    add("multi_r7",   0, 7, 8'h00, 8'h00, 0, 8'h00, 8'h81, 8'h01);
    add("multi_r0",   0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h81, 8'h80);
    add("eoi_zero",   0, 0, 8'h00, 8'h00, 0, 8'h02, 8'h81, 8'h80);
    add("no_latch",   0, 0, 8'h00, 8'h10, 0, 8'h00, 8'h81, 8'h80);

    foreach (vecs[i])
      cycle(vecs[i].name, vecs[i].rst, vecs[i].rot, vecs[i].mask,
            vecs[i].intr, vecs[i].latch, vecs[i].eoi,
            vecs[i].exp_isr, vecs[i].exp_high);

    // Reset asserted while a latch and an EOI are both requested.
    m_isr = 8'h81;
    model_cycle("rst_eoi_latch", 1'b1, 3'd2, 8'h00, 8'h40, 1'b1, 8'h01);

    // Randomised traffic checked against the reference model.
    for (int unsigned n = 0; n < 300; n++) begin
      model_cycle("rand",
                  ($urandom_range(0, 39) == 0),
                  3'($urandom_range(0, 7)),
                  (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00),
                  8'd1 << $urandom_range(0, 7),
                  ($urandom_range(0, 2) == 0),
                  (($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00));
    end

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
